// File: rtl/ransac_sample_sequencer.sv
// ---------------------------------------------------------------------------
// ransac_sample_sequencer
//
// Draws one RANSAC minimal sample: sample_size distinct point indices in
// [0, point_count-1]. Each index is requested from an external
// random_in_range block (base 0, window = latched point_count). Duplicate
// draws are rejected, and the number of rejections per slot is bounded.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   start_valid/ready     upstream request; point_count captured on handshake
//   point_count           population size
//   rng_ivalid/iready     request channel to random_in_range
//   rng_base              always 0
//   rng_max_offset        latched point_count
//   rng_random            drawn value
//   rng_ovalid/oready     result channel from random_in_range
//   sample_valid/ready    downstream handshake
//   sample_indices        slot i at [i*index_width +: index_width]
//   sample_error          1 = aborted sample, indices are meaningless
// ---------------------------------------------------------------------------
module ransac_sample_sequencer #(
    parameter int index_width = 32,
    parameter int sample_size = 3,
    parameter int max_retries = 15
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start_valid,
    output logic                               start_ready,
    input  logic [index_width-1:0]             point_count,
    output logic                               rng_ivalid,
    input  logic                               rng_iready,
    output logic [index_width-1:0]             rng_base,
    output logic [index_width-1:0]             rng_max_offset,
    input  logic [index_width-1:0]             rng_random,
    input  logic                               rng_ovalid,
    output logic                               rng_oready,
    output logic                               sample_valid,
    input  logic                               sample_ready,
    output logic [sample_size*index_width-1:0] sample_indices,
    output logic                               sample_error
);

    localparam int slot_w  = (sample_size > 1) ? $clog2(sample_size) : 1;
    // Must hold max_retries+1, the value at which the slot aborts.
    localparam int retry_w = $clog2(max_retries + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [index_width-1:0]           count_q;
    logic [slot_w-1:0]                slot_q;
    logic [retry_w-1:0]               retry_q;
    logic [sample_size*index_width-1:0] indices_q;
    logic                             error_q;

    logic                             too_small;
    logic                             duplicate;
    logic                             last_slot;
    logic [retry_w-1:0]               retry_next;
    logic                             abort;

    assign too_small  = point_count < index_width'(sample_size);
    assign last_slot  = slot_q == slot_w'(sample_size - 1);
    assign retry_next = retry_q + retry_w'(1);
    assign abort      = retry_next > retry_w'(max_retries);

    // Compare the incoming draw against every slot already filled.
    always_comb begin
        // NOTE: default assignment first so no path leaves duplicate unassigned, which would infer a latch.
        duplicate = 1'b0;
        for (int i = 0; i < sample_size; i++) begin
            if (i < int'(slot_q) &&
                indices_q[i*index_width +: index_width] == rng_random) begin
                duplicate = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_valid) state_d = too_small ? S_DONE : S_REQ;
            S_REQ:  if (rng_iready)  state_d = S_WAIT;
            S_WAIT: begin
                if (rng_ovalid) begin
                    if (!duplicate) state_d = last_slot ? S_DONE : S_REQ;
                    else            state_d = abort     ? S_DONE : S_REQ;
                end
            end
            S_DONE: if (sample_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        start_ready  = 1'b0;
        rng_ivalid   = 1'b0;
        rng_oready   = 1'b0;
        sample_valid = 1'b0;
        unique case (state_q)
            S_IDLE:  start_ready  = 1'b1;
            S_REQ:   rng_ivalid   = 1'b1;
            S_WAIT:  rng_oready   = 1'b1;
            S_DONE:  sample_valid = 1'b1;
            default: start_ready  = 1'b0;
        endcase
    end

    // Datapath: latched count, slot/retry counters, accepted indices, error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            slot_q    <= '0;
            retry_q   <= '0;
            // NOTE: the index store is a handful of flops, not a RAM, so it is reset along with the rest.
            indices_q <= '0;
            error_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start_valid) begin
                count_q <= point_count;
                slot_q  <= '0;
                retry_q <= '0;
                error_q <= too_small;
            end else if (state_q == S_WAIT && rng_ovalid) begin
                if (!duplicate) begin
                    indices_q[int'(slot_q)*index_width +: index_width] <= rng_random;
                    retry_q <= '0;
                    if (!last_slot) slot_q <= slot_q + slot_w'(1);
                end else begin
                    retry_q <= retry_next;
                    if (abort) error_q <= 1'b1;
                end
            end
        end
    end

    assign rng_base       = '0;
    assign rng_max_offset = count_q;
    assign sample_indices = indices_q;
    assign sample_error   = error_q;

    // The generator must stay inside the window it was given.
    a_rng_in_range: assert property (@(posedge clock) disable iff (!reset)
        (state_q == S_WAIT && rng_ovalid) |-> (rng_random < count_q));

endmodule

// File: doc/ransac_sample_sequencer.md
Name: ransac_sample_sequencer

Overview:
- Draws one RANSAC minimal sample of `sample_size` distinct point indices in [0, point_count-1].
- Sequences a `random_in_range` instance: base=0, max_offset=point_count; it rejects duplicate draws and bounds retries.
- Sits between the RANSAC iteration controller (upstream, start handshake) and the model-fit stage (downstream, sample handshake).

Parameters:
- index_width, 32, width of point indices and point_count; equals the random_in_range window width.
- sample_size, 3, indices per sample; legal range 1..8.
- max_retries, 15, duplicate rejections allowed per slot before abort; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_valid  in  1  request for a new sample.
- start_ready  out  1  high only in IDLE.
- point_count  in  index_width  population size; sampled when start_valid && start_ready.
- rng_ivalid  out  1  request to random_in_range.
- rng_iready  in  1  random_in_range accepts a request.
- rng_base  out  index_width  constant 0.
- rng_max_offset  out  index_width  latched point_count.
- rng_random  in  index_width  drawn value.
- rng_ovalid  in  1  drawn value valid.
- rng_oready  out  1  sequencer accepts the drawn value.
- sample_valid  out  1  sample (or error) available.
- sample_ready  in  1  downstream accepts the sample.
- sample_indices  out  sample_size*index_width  slot i occupies bits [i*index_width +: index_width].
- sample_error  out  1  qualifies sample_valid: 1 = abort, indices invalid.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; start_ready=1; rng_ivalid=0; rng_oready=0; sample_valid=0; sample_error=0; sample_indices=0; slot counter=0; retry counter=0; latched count=0.
- FSM states:
  - IDLE: start_ready=1.
    - On start handshake, latch point_count and clear slot and retry counters.
    - If point_count < sample_size (including 0), go to DONE with sample_error=1. No RNG request is issued in this case, so divisor 0 never reaches the divider.
    - Otherwise go to REQ.
  - REQ: rng_ivalid=1. On rng_iready, go to WAIT. rng_ivalid must stay high until accepted.
  - WAIT: rng_oready=1. On rng_ovalid, compare rng_random against accepted slots 0..slot-1 (combinational, same cycle).
    - Unique: write the value to slot[slot] and clear the retry counter. If slot == sample_size-1, go to DONE; else increment slot and go to REQ.
    - Duplicate: increment the retry counter. If the count is now > max_retries, go to DONE with sample_error=1; else go to REQ.
  - DONE: sample_valid=1; sample_indices and sample_error held stable. On sample_ready, go to IDLE and clear sample_valid (sample_indices keep their values).
- Exactly one RNG request is outstanding at a time; rng_oready is 0 outside WAIT.
- Latency, best case: 2 cycles per slot plus the divmod pipeline latency, then DONE.
- rng_base is always 0. rng_max_offset is driven from the latched count, not the live point_count input.
- Out-of-range rng_random (≥ latched count) is a protocol fault. It is flagged by an assertion, not handled.
- start_valid during non-IDLE states is ignored (start_ready=0).
- sample_ready while not in DONE has no effect.
- point_count == sample_size is legal; the sequencer may retry heavily.
- Reset mid-operation returns to IDLE immediately. An in-flight RNG result is then discarded: the divmod shares the reset.

Test Plan:
- point_count=100, sample_size=3, RNG stub returns 7, 42, 99 → sample_valid, indices {7,42,99} in slots 0..2, sample_error=0, exactly 3 rng_ivalid handshakes.
- point_count=100, stub returns 5, 5, 5, 17, 63 → slot1 rejects twice (retry counter 1, 2), final indices {5,17,63}, sample_error=0.
- max_retries=2, stub returns 3, 3, 3, 3 → abort after the third duplicate: sample_valid=1, sample_error=1, 4 requests total.
- point_count=2, sample_size=3 → DONE the cycle after start with sample_error=1, zero rng_ivalid assertions; point_count=0 behaves identically.
- Back-pressure: rng_iready low 5 cycles and sample_ready low 10 cycles → rng_ivalid and sample_valid/indices held stable throughout, then one handshake each.
- Reset asserted in WAIT with rng_ovalid pending → all outputs reach reset values without a clock edge; the next start produces a correct fresh sample.
